jogo_memoria_param: RTL and testbench
=====================================

JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_BOTOES, 4, button/LED channel count; legal values 2, 4, 8.
- PROF, 16, maximum sequence length, i.e. number of rounds; legal range 2..256.
- TIMEOUT, 3000, clock cycles allowed per player action.
- LED_CICLOS, 1000, cycles each element is lit, and also the dark gap after it.
REQ-002 Ports SHALL be (name direction width meaning):
- clock in 1: single clock; all state changes on the rising edge.
- reset in 1: synchronous, active-low reset.
- iniciar in 1: start/restart request, level-sampled.
- modo in 1: 0 = sequence generated internally; 1 = sequence written by the player.
- semente in 8: LFSR seed, latched on start.
- botoes in N_BOTOES: player buttons, active-high, already synchronised.
- leds out N_BOTOES: sequence display, one-hot or zero.
- pronto out 1: game over, in any terminal state.
- ganhou out 1: win.
- perdeu out 1: wrong play.
- timeout out 1: player too slow.
- db_estado out 4: state code.
- db_rodada out clog2(PROF): current round index.
- db_endereco out clog2(PROF): current sequence address.
- db_jogada out clog2(N_BOTOES): index of the last registered button.

Function
REQ-003 Storage SHALL be an internal PROF x clog2(N_BOTOES) register array holding button indices; leds = one-hot of the stored index.
REQ-004 Jogada detection SHALL work as follows:
- A jogada is registered on the cycle in which botoes goes from all-zero (previous cycle) to non-zero.
- A second jogada is not detected until botoes returns to all-zero.
- A press with more than one bit set is an invalid jogada.
REQ-005 States and codes SHALL be:
- INICIAL 0, PREPARA 1, MOSTRA 2, APAGA 3, ESPERA 4, COMPARA 5, PROXIMA 6, NOVA 7, ACERTOU 8, ERROU 9, ESGOTOU 10.
REQ-006 INICIAL SHALL have all outputs low; iniciar=1 latches modo and semente and moves to PREPARA.
REQ-007 PREPARA SHALL behave by mode:
- modo=0: writes PROF entries, one per cycle at addresses 0..PROF-1, entry = low clog2(N_BOTOES) bits of the LFSR, and steps the LFSR after each write; then clears rodada and address and goes to MOSTRA.
- modo=1: one cycle, clears rodada and address, then goes to NOVA.
REQ-008 The LFSR SHALL be 8 bits with taps x^8+x^6+x^5+x^4+1, loaded with semente, or with 8'h01 if semente=0.
REQ-009 MOSTRA/APAGA display SHALL work as follows:
- MOSTRA drives leds for LED_CICLOS cycles; APAGA drives leds=0 for LED_CICLOS cycles.
- After APAGA: if address<rodada, address increments and the FSM returns to MOSTRA; otherwise address clears, the timeout counter clears, and the FSM goes to ESPERA.
REQ-010 ESPERA SHALL behave as follows:
- On a jogada: register its index to db_jogada and go to COMPARA.
- If the timeout counter reaches TIMEOUT-1 with no jogada: go to ESGOTOU.
- A jogada in the same cycle as counter=TIMEOUT-1 wins, i.e. is processed as a jogada.
REQ-011 COMPARA SHALL take one cycle:
- Invalid jogada, or mismatch with memory[address]: go to ERROU.
- Match with address<rodada: address increments, the timeout counter clears, and the FSM returns to ESPERA.
- Match with address=rodada: go to PROXIMA.
REQ-012 PROXIMA SHALL take one cycle:
- If rodada=PROF-1: go to ACERTOU.
- Otherwise rodada increments and address clears; modo=0 then goes to MOSTRA, modo=1 goes to NOVA with the timeout counter cleared.
REQ-013 NOVA (modo=1 only) SHALL behave as follows:
- Waits for a jogada, subject to the same timeout rule as ESPERA.
- A valid jogada is written to memory[rodada]; the FSM then clears address and goes to MOSTRA.
- An invalid jogada goes to ERROU.
REQ-014 Terminal states SHALL behave as follows:
- ACERTOU: ganhou=1. ERROU: perdeu=1. ESGOTOU: timeout=1.
- pronto=1 in all three.
- These outputs are held until iniciar=1, which moves directly to PREPARA (restart) and drops them on the next cycle.
REQ-015 iniciar SHALL be ignored in every non-terminal state except INICIAL.
REQ-016 Counters SHALL never wrap silently:
- rodada and address saturate at PROF-1.
- LED and timeout counters are wide enough for max(TIMEOUT, LED_CICLOS).

Reset
REQ-017 reset=0 on a clock edge SHALL return the FSM to INICIAL from any state, including mid-display and mid-fill.
REQ-018 On that reset, all outputs, counters, rodada, address, db_jogada and the LFSR SHALL clear to 0; memory contents are don't-care.
REQ-019 reset SHALL take priority over iniciar and over any jogada in the same cycle.

Verification (N_BOTOES=4, PROF=4, TIMEOUT=10, LED_CICLOS=2)
REQ-020 modo=1 full win: press sequence 2; 2,1; 2,1,3; 2,1,3,0 plus repeats -> after the fourth repeat, ganhou=pronto=1 and db_estado=8; LEDs show 0100, then 0100,0010, and so on, each lit 2 cycles.
REQ-021 modo=1 wrong play: store 2, then repeat with 1 (botoes=0010) -> COMPARA, then ERROU; perdeu=1, db_rodada=0, db_jogada=1.
REQ-022 Timeout: enter ESPERA with no press for 10 cycles -> timeout=1 and pronto=1 on cycle 10; ganhou=perdeu=0.
REQ-023 modo=0, semente=8'h00: memory is filled from LFSR seed 8'h01; the first leds value equals the one-hot of the seed's low 2 bits (0010); the model-predicted sequence, when played back, ends in ACERTOU.
REQ-024 Boundaries:
- botoes=0011 in ESPERA -> ERROU.
- Holding a button for 5 cycles counts once.
- reset=0 during MOSTRA -> INICIAL next edge with leds=0.
- iniciar in ERROU -> PREPARA with perdeu=0.

Source files
------------

// File: rtl/jogo_memoria_param.sv
// Memory game: replays a growing button sequence on the LEDs and checks the
// player's repetition; the sequence comes from an LFSR or from the player.
module jogo_memoria_param #(
  parameter int N_BOTOES   = 4,
  parameter int PROF       = 16,
  parameter int TIMEOUT    = 3000,
  parameter int LED_CICLOS = 1000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iniciar,
  input  logic                        modo,
  input  logic [7:0]                  semente,
  input  logic [N_BOTOES-1:0]         botoes,
  output logic [N_BOTOES-1:0]         leds,
  output logic                        pronto,
  output logic                        ganhou,
  output logic                        perdeu,
  output logic                        timeout,
  output logic [3:0]                  db_estado,
  output logic [$clog2(PROF)-1:0]     db_rodada,
  output logic [$clog2(PROF)-1:0]     db_endereco,
  output logic [$clog2(N_BOTOES)-1:0] db_jogada
);
  localparam int AW   = $clog2(PROF);
  localparam int BW   = $clog2(N_BOTOES);
  localparam int CMAX = (TIMEOUT > LED_CICLOS) ? TIMEOUT : LED_CICLOS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW-1:0]       ULTIMO  = AW'(PROF - 1);
  localparam logic [CW-1:0]       LED_FIM = CW'(LED_CICLOS - 1);
  localparam logic [CW-1:0]       TMO_FIM = CW'(TIMEOUT - 1);
  localparam logic [N_BOTOES-1:0] UM      = N_BOTOES'(1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,  PREPARA = 4'd1, MOSTRA  = 4'd2, APAGA   = 4'd3,
    ESPERA  = 4'd4,  COMPARA = 4'd5, PROXIMA = 4'd6, NOVA    = 4'd7,
    ACERTOU = 4'd8,  ERROU   = 4'd9, ESGOTOU = 4'd10
  } estado_t;

  estado_t             estado;
  logic [BW-1:0]       mem [PROF];
  logic [AW-1:0]       rodada, endereco;
  logic [CW-1:0]       led_cnt, tmo_cnt;
  logic [7:0]          lfsr;
  logic                modo_r;
  logic [N_BOTOES-1:0] botoes_ant;
  logic                jogada_valida;

  logic                jogada, jogada_ok;
  logic [BW-1:0]       jogada_idx;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [BW-1:0]       mem_dado;

  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_prox(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == ULTIMO) ? v : v + AW'(1);
  endfunction

  // A press is the edge from all-released to anything pressed.
  assign jogada    = (botoes_ant == '0) && (botoes != '0);
  assign jogada_ok = $onehot(botoes);

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    jogada_idx = '0;
    for (int i = N_BOTOES - 1; i >= 0; i--)
      if (botoes[i]) jogada_idx = BW'(i);
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = endereco;
    mem_dado = lfsr[BW-1:0];
    if (estado == PREPARA && !modo_r) begin
      mem_we = 1'b1;
    end else if (estado == NOVA && jogada && jogada_ok) begin
      mem_we   = 1'b1;
      mem_addr = rodada;
      mem_dado = jogada_idx;
    end
  end

  // NOTE: the sequence store has no reset; its contents are rewritten before use.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem[mem_addr] <= mem_dado;
  end

  // NOTE: all state uses <= so each register sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= INICIAL;
      rodada        <= '0;
      endereco      <= '0;
      led_cnt       <= '0;
      tmo_cnt       <= '0;
      lfsr          <= '0;
      modo_r        <= 1'b0;
      botoes_ant    <= '0;
      db_jogada     <= '0;
      jogada_valida <= 1'b0;
    end else begin
      botoes_ant <= botoes;
      unique case (estado)
        INICIAL, ACERTOU, ERROU, ESGOTOU: begin
          if (iniciar) begin
            modo_r   <= modo;
            lfsr     <= (semente == 8'h00) ? 8'h01 : semente;
            rodada   <= '0;
            endereco <= '0;
            estado   <= PREPARA;
          end
        end
        PREPARA: begin
          if (modo_r) begin
            rodada   <= '0;
            endereco <= '0;
            tmo_cnt  <= '0;
            estado   <= NOVA;
          end else begin
            lfsr <= lfsr_prox(lfsr);
            if (endereco == ULTIMO) begin
              endereco <= '0;
              rodada   <= '0;
              led_cnt  <= '0;
              estado   <= MOSTRA;
            end else begin
              endereco <= sat_inc(endereco);
            end
          end
        end
        MOSTRA: begin
          if (led_cnt == LED_FIM) begin
            led_cnt <= '0;
            estado  <= APAGA;
          end else begin
            led_cnt <= led_cnt + CW'(1);
          end
        end
        APAGA: begin
          if (led_cnt == LED_FIM) begin
            led_cnt <= '0;
            if (endereco < rodada) begin
              endereco <= sat_inc(endereco);
              estado   <= MOSTRA;
            end else begin
              endereco <= '0;
              tmo_cnt  <= '0;
              estado   <= ESPERA;
            end
          end else begin
            led_cnt <= led_cnt + CW'(1);
          end
        end
        ESPERA: begin
          if (jogada) begin
            db_jogada     <= jogada_idx;
            jogada_valida <= jogada_ok;
            estado        <= COMPARA;
          end else if (tmo_cnt == TMO_FIM) begin
            estado <= ESGOTOU;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        COMPARA: begin
          if (!jogada_valida || db_jogada != mem[endereco]) begin
            estado <= ERROU;
          end else if (endereco < rodada) begin
            endereco <= sat_inc(endereco);
            tmo_cnt  <= '0;
            estado   <= ESPERA;
          end else begin
            estado <= PROXIMA;
          end
        end
        PROXIMA: begin
          if (rodada == ULTIMO) begin
            estado <= ACERTOU;
          end else begin
            rodada   <= sat_inc(rodada);
            endereco <= '0;
            if (modo_r) begin
              tmo_cnt <= '0;
              estado  <= NOVA;
            end else begin
              led_cnt <= '0;
              estado  <= MOSTRA;
            end
          end
        end
        NOVA: begin
          if (jogada) begin
            db_jogada <= jogada_idx;
            if (jogada_ok) begin
              endereco <= '0;
              led_cnt  <= '0;
              estado   <= MOSTRA;
            end else begin
              estado <= ERROU;
            end
          end else if (tmo_cnt == TMO_FIM) begin
            estado <= ESGOTOU;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    if (estado == MOSTRA) leds = UM << mem[endereco];
  end

  assign ganhou      = (estado == ACERTOU);
  assign perdeu      = (estado == ERROU);
  assign timeout     = (estado == ESGOTOU);
  assign pronto      = ganhou || perdeu || timeout;
  assign db_estado   = estado;
  assign db_rodada   = rodada;
  assign db_endereco = endereco;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param: random games in both modes checked
// against a game-rule model, plus timeout, invalid-press and reset scenarios.
module tb_jogo_memoria_param;
  localparam int NB = 4;
  localparam int PF = 4;
  localparam int TO = 10;
  localparam int LC = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar = 1'b0;
  logic          modo = 1'b0;
  logic [7:0]    semente = 8'h00;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          pronto, ganhou, perdeu, timeout;
  logic [3:0]    db_estado;
  logic [1:0]    db_rodada, db_endereco, db_jogada;

  int n_tests = 0;
  int n_fail  = 0;

  jogo_memoria_param #(
    .N_BOTOES(NB), .PROF(PF), .TIMEOUT(TO), .LED_CICLOS(LC)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
    .semente(semente), .botoes(botoes), .leds(leds), .pronto(pronto),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado), .db_rodada(db_rodada),
    .db_endereco(db_endereco), .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model pieces: the LFSR polynomial and the one-hot button map.
  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [NB-1:0] onehot(input int i);
    logic [NB-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    iniciar = 1'b0;
    botoes  = '0;
    reset   = 1'b0;
    step();
    step();
    reset   = 1'b1;
  endtask

  task automatic start(input logic m, input logic [7:0] s);
    modo    = m;
    semente = s;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic press(input logic [NB-1:0] v);
    botoes = v;
    step();
    botoes = '0;
  endtask

  // Player-authored game: store `first`, watch it, end up waiting for the repeat.
  task automatic to_espera(input int first);
    do_reset();
    start(1'b1, 8'h00);
    step();
    press(onehot(first));
    repeat (2 * LC) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_endereco, db_jogada} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got leds=%b flags=%b%b%b%b estado=%0d want all zero",
               leds, pronto, ganhou, perdeu, timeout, db_estado);
    end
    reset = 1'b0; iniciar = 1'b1;
    step();
    n_tests++;
    if (db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_over_iniciar: estado got %0d want 0", db_estado);
    end
    iniciar = 1'b0; reset = 1'b1;
  endtask

  // Full game driven by the model; err_round<0 plays perfectly.
  task automatic test_game(input logic m, input logic [7:0] seed, input bit fixed,
                           input int err_round, input int err_pos);
    int            seq [PF];
    logic [7:0]    l;
    int            v;
    bit            wrong;
    logic [NB-1:0] exp_leds;
    l = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < PF; i++) begin
      if (fixed)  seq[i] = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 3 : 0;
      else if (m) seq[i] = $urandom_range(NB - 1, 0);
      else begin
        seq[i] = int'(l[1:0]);
        l = lfsr_model(l);
      end
    end
    do_reset();
    start(m, seed);
    if (m) step();
    else repeat (PF) step();
    for (int r = 0; r < PF; r++) begin
      if (m) begin
        n_tests++;
        if (db_estado !== 4'd7) begin
          n_fail++;
          $display("FAIL game_nova m=%0d r=%0d: estado got %0d want 7", m, r, db_estado);
        end
        press(onehot(seq[r]));
      end
      for (int k = 0; k < (r + 1) * 2 * LC; k++) begin
        exp_leds = ((k % (2 * LC)) < LC) ? onehot(seq[k / (2 * LC)]) : '0;
        n_tests++;
        if (leds !== exp_leds) begin
          n_fail++;
          $display("FAIL game_leds m=%0d r=%0d k=%0d: got %b want %b", m, r, k, leds, exp_leds);
        end
        step();
      end
      n_tests++;
      if (db_estado !== 4'd4) begin
        n_fail++;
        $display("FAIL game_espera m=%0d r=%0d: estado got %0d want 4", m, r, db_estado);
      end
      for (int i = 0; i <= r; i++) begin
        wrong = (r == err_round) && (i == err_pos);
        v = wrong ? (seq[i] + 1 + $urandom_range(NB - 2, 0)) % NB : seq[i];
        press(onehot(v));
        n_tests++;
        if (db_estado !== 4'd5 || db_jogada !== 2'(v)) begin
          n_fail++;
          $display("FAIL game_compara m=%0d r=%0d i=%0d: estado=%0d jogada=%0d want 5/%0d",
                   m, r, i, db_estado, db_jogada, v);
        end
        step();
        if (wrong) begin
          n_tests++;
          if (db_estado !== 4'd9 || !perdeu || !pronto || ganhou || db_rodada !== 2'(r)) begin
            n_fail++;
            $display("FAIL game_errou m=%0d r=%0d: estado=%0d perdeu=%b pronto=%b rodada=%0d want 9/1/1/%0d",
                     m, r, db_estado, perdeu, pronto, db_rodada, r);
          end
          return;
        end
        n_tests++;
        if (db_estado !== ((i < r) ? 4'd4 : 4'd6)) begin
          n_fail++;
          $display("FAIL game_after_compara m=%0d r=%0d i=%0d: estado got %0d want %0d",
                   m, r, i, db_estado, (i < r) ? 4 : 6);
        end
      end
      step();
    end
    n_tests++;
    if (db_estado !== 4'd8 || !ganhou || !pronto || perdeu || timeout) begin
      n_fail++;
      $display("FAIL game_win m=%0d: estado=%0d ganhou=%b pronto=%b perdeu=%b timeout=%b want 8/1/1/0/0",
               m, db_estado, ganhou, pronto, perdeu, timeout);
    end
  endtask

  task automatic test_wrong_play();
    to_espera(2);
    press(onehot(1));
    n_tests++;
    if (db_estado !== 4'd5) begin
      n_fail++;
      $display("FAIL wrong_compara: estado got %0d want 5", db_estado);
    end
    step();
    n_tests++;
    if (db_estado !== 4'd9 || perdeu !== 1'b1 || db_rodada !== 2'd0 || db_jogada !== 2'd1) begin
      n_fail++;
      $display("FAIL wrong_errou: estado=%0d perdeu=%b rodada=%0d jogada=%0d want 9/1/0/1",
               db_estado, perdeu, db_rodada, db_jogada);
    end
  endtask

  task automatic test_timeout();
    to_espera(3);
    for (int c = 1; c < TO; c++) begin
      step();
      n_tests++;
      if (db_estado !== 4'd4) begin
        n_fail++;
        $display("FAIL timeout_wait c=%0d: estado got %0d want 4", c, db_estado);
      end
    end
    step();
    n_tests++;
    if (db_estado !== 4'd10 || !timeout || !pronto || ganhou || perdeu) begin
      n_fail++;
      $display("FAIL timeout_esgotou: estado=%0d timeout=%b pronto=%b ganhou=%b perdeu=%b want 10/1/1/0/0",
               db_estado, timeout, pronto, ganhou, perdeu);
    end
    // Press on the last allowed cycle is still taken as a play.
    to_espera(3);
    repeat (TO - 1) step();
    press(onehot(3));
    n_tests++;
    if (db_estado !== 4'd5) begin
      n_fail++;
      $display("FAIL timeout_last_cycle_press: estado got %0d want 5", db_estado);
    end
    do_reset();
    start(1'b1, 8'h00);
    step();
    repeat (TO) step();
    n_tests++;
    if (db_estado !== 4'd10 || !timeout) begin
      n_fail++;
      $display("FAIL timeout_nova: estado=%0d timeout=%b want 10/1", db_estado, timeout);
    end
  endtask

  task automatic test_invalid_press();
    to_espera(0);
    press(4'b0011);
    step();
    n_tests++;
    if (db_estado !== 4'd9 || !perdeu) begin
      n_fail++;
      $display("FAIL invalid_espera: estado=%0d perdeu=%b want 9/1", db_estado, perdeu);
    end
    do_reset();
    start(1'b1, 8'h00);
    step();
    press(4'b0011);
    n_tests++;
    if (db_estado !== 4'd9 || !perdeu) begin
      n_fail++;
      $display("FAIL invalid_nova: estado=%0d perdeu=%b want 9/1", db_estado, perdeu);
    end
  endtask

  task automatic test_hold();
    to_espera(2);
    botoes = onehot(2);
    repeat (5) step();
    n_tests++;
    if (db_estado !== 4'd7 || db_rodada !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_counts_once: estado=%0d rodada=%0d want 7/1", db_estado, db_rodada);
    end
    botoes = '0;
    step();
    press(onehot(1));
    n_tests++;
    if (db_estado !== 4'd2 || leds !== onehot(2)) begin
      n_fail++;
      $display("FAIL hold_rearm: estado=%0d leds=%b want 2/%b", db_estado, leds, onehot(2));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(1'b1, 8'h00);
    step();
    press(onehot(3));
    n_tests++;
    if (leds !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_mostra_leds: got %b want 1000", leds);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (db_estado !== 4'd0 || leds !== '0 || db_jogada !== '0 || pronto) begin
      n_fail++;
      $display("FAIL mid_mostra_reset: estado=%0d leds=%b jogada=%0d want 0/0000/0",
               db_estado, leds, db_jogada);
    end
    reset = 1'b1;
    start(1'b0, 8'($urandom));
    step();
    reset = 1'b0;
    step();
    n_tests++;
    if (db_estado !== 4'd0 || db_endereco !== '0) begin
      n_fail++;
      $display("FAIL mid_fill_reset: estado=%0d endereco=%0d want 0/0", db_estado, db_endereco);
    end
    reset = 1'b1;
    to_espera(1);
    reset = 1'b0;
    botoes = onehot(1);
    step();
    botoes = '0;
    n_tests++;
    if (db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_over_jogada: estado got %0d want 0", db_estado);
    end
    reset = 1'b1;
  endtask

  task automatic test_restart();
    to_espera(2);
    iniciar = 1'b1;
    repeat (3) step();
    iniciar = 1'b0;
    n_tests++;
    if (db_estado !== 4'd4) begin
      n_fail++;
      $display("FAIL iniciar_ignored: estado got %0d want 4", db_estado);
    end
    press(onehot(1));
    step();
    iniciar = 1'b1;
    modo    = 1'b1;
    step();
    iniciar = 1'b0;
    n_tests++;
    if (db_estado !== 4'd1 || perdeu || pronto) begin
      n_fail++;
      $display("FAIL restart_errou: estado=%0d perdeu=%b pronto=%b want 1/0/0", db_estado, perdeu, pronto);
    end
    step();
    n_tests++;
    if (db_estado !== 4'd7 || db_rodada !== 2'd0) begin
      n_fail++;
      $display("FAIL restart_nova: estado=%0d rodada=%0d want 7/0", db_estado, db_rodada);
    end
  endtask

  initial begin
    int er;
    test_reset();
    test_game(1'b1, 8'h00, 1'b1, -1, 0);
    repeat (3) test_game(1'b1, 8'($urandom), 1'b0, -1, 0);
    test_game(1'b0, 8'h00, 1'b0, -1, 0);
    repeat (3) test_game(1'b0, 8'($urandom), 1'b0, -1, 0);
    repeat (4) begin
      er = $urandom_range(PF - 1, 0);
      test_game(1'($urandom), 8'($urandom), 1'b0, er, $urandom_range(er, 0));
    end
    test_wrong_play();
    test_timeout();
    test_invalid_press();
    test_hold();
    test_reset_mid();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
